// File: rtl/seg_dyn_hex.sv
// ---------------------------------------------------------------------------
// seg_dyn_hex
//   Multiplexed (dynamic-scan) hex driver for a DIGITS-digit common-anode
//   7-segment display. Each digit gets its own nibble and decimal point.
//   Optional leading-zero suppression is available. Every digit slot starts
//   with a short all-dark gap so the previous digit does not ghost into the
//   next one. New content goes into a pending buffer. It is promoted to the
//   active buffer only at the frame wrap, so a frame never shows a mix of
//   old and new values.
//
// Ports
//   sys_clk      in   system clock
//   sys_rst      in   asynchronous, active-high reset
//   data         in   packed nibbles, data[4i+3:4i] is digit i (0 = rightmost)
//   dp           in   decimal point per digit, 1 = lit
//   lz_en        in   leading-zero suppression enable, captured with load
//   load         in   one-cycle strobe, captures data/dp/lz_en into pending
//   sel          out  one-hot digit enables at level SEL_ACT
//   seg          out  active-low segments {dp,g,f,e,d,c,b,a}, 8'hFF = dark
//   frame_start  out  one-cycle pulse when the scan wraps back to digit 0
// ---------------------------------------------------------------------------
module seg_dyn_hex #(
    parameter int          DIGITS    = 6,
    parameter logic [15:0] SCAN_MAX  = 16'd49_999,
    parameter logic [15:0] BLANK_CYC = 16'd500,
    parameter logic        SEL_ACT   = 1'b0
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    // Active-low glyph table; bit 7 (dp) is left dark here.
    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    // ---------------- state ----------------
    logic [15:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   pend_data_q, pend_data_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                  pend_lz_q, pend_lz_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [4*DIGITS-1:0]   act_data_q, act_data_d;
    logic [DIGITS-1:0]     act_dp_q, act_dp_d;
    logic                  act_lz_q, act_lz_d;
    logic [DIGITS-1:0]     sel_q, sel_d;
    logic [7:0]            seg_q, seg_d;
    logic                  frame_start_q, frame_start_d;

    logic                  tick;
    logic                  frame_wrap;
    logic                  swap;

    assign tick       = (cnt_q == SCAN_MAX);
    assign frame_wrap = tick && (idx_q == LAST_IDX);
    // Promotion uses the pending contents as they were before this edge,
    // so a load landing on the wrap cycle waits for the next frame.
    assign swap       = frame_wrap && pend_valid_q;

    // ---------------- scan counter / digit index ----------------
    always_comb begin
        cnt_d         = tick ? 16'd0 : cnt_q + 16'd1;
        idx_d         = idx_q;
        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        frame_start_d = frame_wrap;
    end

    // ---------------- double buffer ----------------
    always_comb begin
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_lz_d    = pend_lz_q;
        pend_valid_d = pend_valid_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_lz_d     = act_lz_q;

        if (swap) begin
            act_data_d   = pend_data_q;
            act_dp_d     = pend_dp_q;
            act_lz_d     = pend_lz_q;
            pend_valid_d = 1'b0;
        end
        // A load always wins over the clear, so pending stays valid if both
        // happen on the same cycle.
        if (load) begin
            pend_data_d  = data;
            pend_dp_d    = dp;
            pend_lz_d    = lz_en;
            pend_valid_d = 1'b1;
        end
    end

    // ---------------- leading-zero suppression ----------------
    // Walk from the most significant digit down; a digit is suppressed while
    // every nibble at or above it is zero. Digit 0 always shows.
    logic [DIGITS-1:0] suppress;
    logic              zero_run;

    always_comb begin
        suppress = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run & (act_data_q[4*i +: 4] == 4'h0);
            suppress[i] = act_lz_q & zero_run & (i != 0);
        end
    end

    // ---------------- per-digit segment patterns ----------------
    logic [7:0] digit_seg [DIGITS];
    logic [7:0] glyph_full [DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign glyph_full[gi] = hex_glyph(act_data_q[4*gi +: 4]);
            assign digit_seg[gi]  = {~act_dp_q[gi],
                                     suppress[gi] ? 7'h7F : glyph_full[gi][6:0]};
        end
    endgenerate

    // ---------------- registered output path ----------------
    always_comb begin
        sel_d = {DIGITS{~SEL_ACT}};
        seg_d = 8'hFF;
        if (cnt_q >= BLANK_CYC) begin
            sel_d[idx_q] = SEL_ACT;
            seg_d        = digit_seg[idx_q];
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_lz_q     <= 1'b0;
            pend_valid_q  <= 1'b0;
            act_data_q    <= '0;
            act_dp_q      <= '0;
            act_lz_q      <= 1'b0;
            sel_q         <= {DIGITS{~SEL_ACT}};
            seg_q         <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_lz_q     <= pend_lz_d;
            pend_valid_q  <= pend_valid_d;
            act_data_q    <= act_data_d;
            act_dp_q      <= act_dp_d;
            act_lz_q      <= act_lz_d;
            sel_q         <= sel_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign sel         = sel_q;
    assign seg         = seg_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_dyn_hex.sv
// ---------------------------------------------------------------------------
// tb_seg_dyn_hex
//   Scoreboard bench for seg_dyn_hex (DIGITS=6, SCAN_MAX=9, BLANK_CYC=2,
//   SEL_ACT=0). The stimulus process pushes the hand-computed six digit
//   windows of each frame as that frame begins. The monitor pops one entry
//   each time a digit window opens and checks the following:
//     - window content and stability,
//     - window length (8 cycles),
//     - dark outputs during blanking,
//     - the 60-cycle frame_start period.
// ---------------------------------------------------------------------------
module tb_seg_dyn_hex;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [23:0] data    = '0;
    logic [5:0]  dp      = '0;
    logic        lz_en   = 1'b0;
    logic        load    = 1'b0;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic        frame_start;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [5:0] sel;
        logic [7:0] seg;
    } exp_t;

    exp_t exp_q[$];

    seg_dyn_hex #(
        .DIGITS   (6),
        .SCAN_MAX (16'd9),
        .BLANK_CYC(16'd2),
        .SEL_ACT  (1'b0)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .data       (data),
        .dp         (dp),
        .lz_en      (lz_en),
        .load       (load),
        .sel        (sel),
        .seg        (seg),
        .frame_start(frame_start)
    );

    always #5 sys_clk = ~sys_clk;

    // Frame images: {digit5, digit4, ..., digit0}
    localparam logic [47:0] FR_ZERO  = {6{8'hC0}};
    localparam logic [47:0] FR_A     = {8'hF9, 8'hA4, 8'h30, 8'h99, 8'h88, 8'h8E};
    localparam logic [47:0] FR_LZ50  = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h92, 8'hC0};
    localparam logic [47:0] FR_LZ0   = {{5{8'hFF}}, 8'hC0};
    localparam logic [47:0] FR_ONES  = {6{8'hF9}};
    localparam logic [47:0] FR_TWOS  = {6{8'hA4}};
    localparam logic [47:0] FR_BS    = {6{8'h83}};

    task automatic push_frame(input logic [47:0] segs);
        exp_t       e;
        logic [5:0] one_hot;
        for (int d = 0; d < 6; d++) begin
            one_hot = 6'b000001 << d;
            e.sel   = ~one_hot;
            e.seg   = segs[8*d +: 8];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_fs();
        bit found = 1'b0;
        int n     = 0;
        while (!found && n < 200) begin
            @(negedge sys_clk);
            if (frame_start) found = 1'b1;
            n++;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL fs_timeout: no frame_start within %0d cycles, required one", n);
        end
    endtask

    // Waits wait_cyc rising edges, then presents a one-cycle load.
    task automatic mid_load(input int wait_cyc, input logic [23:0] d_in,
                            input logic [5:0] dp_in, input logic lz_in);
        repeat (wait_cyc) @(posedge sys_clk);
        #1;
        data  = d_in;
        dp    = dp_in;
        lz_en = lz_in;
        load  = 1'b1;
        @(posedge sys_clk);
        #1;
        load  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        tests++;
        if (sel !== 6'h3F || seg !== 8'hFF || frame_start !== 1'b0) begin
            fails++;
            $display("FAIL %s: sel=%b seg=%h fs=%b, required sel=111111 seg=ff fs=0",
                     tag, sel, seg, frame_start);
        end
    endtask

    // ---------------- monitor ----------------
    exp_t       mon_e;
    logic [5:0] cur_sel;
    logic [7:0] cur_seg;
    bit         in_win  = 1'b0;
    int         run     = 0;
    bit         fs_seen = 1'b0;
    int         fs_cnt  = 0;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            in_win  = 1'b0;
            run     = 0;
            fs_seen = 1'b0;
            fs_cnt  = 0;
        end else begin
            fs_cnt++;
            if (frame_start) begin
                if (fs_seen) begin
                    tests++;
                    if (fs_cnt != 60) begin
                        fails++;
                        $display("FAIL fs_period: got %0d cycles, required 60", fs_cnt);
                    end
                end
                fs_seen = 1'b1;
                fs_cnt  = 0;
            end

            if (sel != 6'h3F) begin
                if (!in_win) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL underflow: window sel=%b seg=%h with nothing expected", sel, seg);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (sel !== mon_e.sel || seg !== mon_e.seg) begin
                            fails++;
                            $display("FAIL digit: sel=%b seg=%h, required sel=%b seg=%h",
                                     sel, seg, mon_e.sel, mon_e.seg);
                        end
                    end
                    cur_sel = sel;
                    cur_seg = seg;
                    run     = 1;
                    in_win  = 1'b1;
                end else begin
                    tests++;
                    if (sel !== cur_sel || seg !== cur_seg) begin
                        fails++;
                        $display("FAIL stable: sel=%b seg=%h, required sel=%b seg=%h",
                                 sel, seg, cur_sel, cur_seg);
                    end
                    run++;
                end
            end else begin
                if (in_win) begin
                    tests++;
                    if (run != 8) begin
                        fails++;
                        $display("FAIL win_len: window lasted %0d cycles, required 8", run);
                    end
                    in_win = 1'b0;
                end
                tests++;
                if (seg !== 8'hFF) begin
                    fails++;
                    $display("FAIL blank: seg=%h while sel dark, required ff", seg);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        @(posedge sys_clk);
        #1;
        check_reset_state("reset_init");
        repeat (2) @(negedge sys_clk);
        push_frame(FR_ZERO);                 // F0: power-on content
        sys_rst = 1'b0;

        wait_fs();                           // F1: still zeros, load mid-frame
        push_frame(FR_ZERO);
        mid_load(20, 24'h12_34AF, 6'b001000, 1'b0);

        wait_fs();                           // F2: 1234AF, dp on digit 3
        push_frame(FR_A);
        mid_load(20, 24'h00_0050, 6'b000000, 1'b1);

        wait_fs();                           // F3: 50 with suppression
        push_frame(FR_LZ50);
        mid_load(20, 24'h00_0000, 6'b000000, 1'b1);

        wait_fs();                           // F4: only digit 0 shown
        push_frame(FR_LZ0);
        mid_load(20, 24'h11_1111, 6'b000000, 1'b0);   // load sampled at edge 21
        // Edges 22..59, then load is sampled exactly on the wrap edge 60.
        mid_load(38, 24'h22_2222, 6'b000000, 1'b0);

        wait_fs();                           // F5: old pending (ones)
        push_frame(FR_ONES);

        wait_fs();                           // F6: load from the wrap cycle
        push_frame(FR_TWOS);
        mid_load(20, 24'hAA_AAAA, 6'b000000, 1'b0);
        mid_load(5,  24'hBB_BBBB, 6'b000000, 1'b0);

        wait_fs();                           // F7: last load wins
        push_frame(FR_BS);
        mid_load(20, 24'h55_5555, 6'b000000, 1'b0);
        repeat (10) @(posedge sys_clk);
        #2;
        sys_rst = 1'b1;                      // asynchronous, between edges
        #1;
        check_reset_state("reset_async");
        exp_q.delete();                      // rest of F7 is never shown
        push_frame(FR_ZERO);
        repeat (3) @(negedge sys_clk);
        check_reset_state("reset_hold");
        sys_rst = 1'b0;

        wait_fs();                           // second frame after reset
        push_frame(FR_ZERO);                 // pending 555555 was discarded
        wait_fs();

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: %0d expected windows not shown, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
